hilo_unit: RTL

HI/LO register stage directly downstream of the execute-stage ALU. It captures the 64-bit result that the ALU produces for mult, multu, div, divu, mthi and mtlo. It holds that result in a single memory-stage slot and commits it to the architectural HI/LO pair only when the instruction leaves the memory stage without an exception. It also returns a forwarded 64-bit HI/LO value to the ALU's `hilo` input, so back-to-back HI/LO producers and consumers see the correct value.

---
 rtl/hilo_unit.sv | 76 +++++++
 1 files changed

// File: rtl/hilo_unit.sv
// HI/LO register stage that sits downstream of the execute-stage ALU.
// A result from mult/multu/div/divu/mthi/mtlo is captured into a single
// memory-stage slot. It is committed to the architectural HI/LO pair when
// that instruction leaves the memory stage without an exception. The pending
// value is forwarded back to the ALU so that back-to-back HI/LO users see the
// newest value.
//
// Ports:
//   clk        pipeline clock, rising edge
//   rst        synchronous active-high reset
//   hilo_weE   execute-stage instruction writes HI/LO
//   aluoutE    ALU result {HI, LO}
//   div_stallE divider busy; aluoutE not yet final
//   stallE     execute stage held this cycle
//   stallM     memory stage held this cycle
//   flushM     kill the memory-stage slot
//   exceptM    memory-stage instruction raises an exception
//   hiloE      forwarded {HI, LO} for the ALU
//   hi_o/lo_o  architectural HI / LO
//   pendingM   memory slot holds an uncommitted HI/LO write
module hilo_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        hilo_weE,
  input  logic [63:0] aluoutE,
  input  logic        div_stallE,
  input  logic        stallE,
  input  logic        stallM,
  input  logic        flushM,
  input  logic        exceptM,
  output logic [63:0] hiloE,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        pendingM
);

  logic        valid_q;
  logic [63:0] data_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        commit;
  logic        capture_valid;

  // The slot retires into HI/LO only when it actually advances out of M
  // cleanly: not held, not killed, and no exception.
  assign commit        = valid_q & ~exceptM & ~stallM & ~flushM;
  // A stalled E stage or a busy divider means the E instruction does not move
  // into M this edge, so a bubble is inserted instead.
  assign capture_valid = hilo_weE & ~stallE & ~div_stallE;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= 64'h0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
    end else begin
      if (commit) begin
        hi_q <= data_q[63:32];
        lo_q <= data_q[31:0];
      end
      if (flushM) begin
        valid_q <= 1'b0;
      end else if (!stallM) begin
        valid_q <= capture_valid;
        data_q  <= aluoutE;
      end
    end
  end

  assign hiloE    = valid_q ? data_q : {hi_q, lo_q};
  assign pendingM = valid_q;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

endmodule
